// File: rtl/fsm_seqgen_pkg.sv
// Shared definitions for the serial pattern transmitter: state encoding,
// default sizes and the length clamp.
package fsm_seqgen_pkg;

  localparam int PAT_W_DEF = 8;
  localparam int REP_W_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Requested length saturates at the pattern register width.
  function automatic int unsigned clamp_len(input int unsigned l, input int unsigned max_l);
    return (l > max_l) ? max_l : l;
  endfunction

endpackage

// File: rtl/fsm_sequence_generator_ctr.sv
// seqgen_ctr: loadable down-counter with a zero flag; load wins over decrement.
module seqgen_ctr #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/fsm_sequence_generator.sv
// Serial pattern transmitter, MSB of the active length first, with repeat count.
// Define SEQGEN_GAP_EN to insert one idle cycle between consecutive passes.
import fsm_seqgen_pkg::*;

module fsm_sequence_generator #(
  parameter  int PAT_W = PAT_W_DEF,
  parameter  int REP_W = REP_W_DEF,
  localparam int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [LEN_W-1:0] len,
  input  logic [REP_W-1:0] reps,
  input  logic             abort,
  output logic             ready,
  output logic             O,
  output logic             O_valid,
  output logic             done
);

  localparam int IDX_W = $clog2(PAT_W);

  state_t           state;
  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] len_c;

  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_load_val;
  logic             idx_zero;
  logic             idx_load;
  logic             idx_dec;
  logic [REP_W-1:0] rep_cnt;
  logic             rep_zero;

  logic accept;
  logic wrap;

  assign len_c  = LEN_W'(clamp_len(32'(len), 32'(PAT_W)));
  assign accept = (state == IDLE) && start && (len != '0);
  // End of a pass with passes remaining: reload the bit index.
  assign wrap   = (state == SHIFT) && !abort && idx_zero && !rep_zero;

  assign idx_load     = accept || wrap;
  assign idx_load_val = accept ? IDX_W'(len_c - LEN_W'(1)) : IDX_W'(len_q - LEN_W'(1));
  assign idx_dec      = (state == SHIFT) && !abort && !idx_zero;

  seqgen_ctr #(.W(IDX_W)) u_idx (
    .clk      (clk),
    .rst      (rst),
    .load     (idx_load),
    .load_val (idx_load_val),
    .dec      (idx_dec),
    .cnt      (idx),
    .zero     (idx_zero)
  );

  seqgen_ctr #(.W(REP_W)) u_rep (
    .clk      (clk),
    .rst      (rst),
    .load     (accept),
    .load_val (reps),
    .dec      (wrap),
    .cnt      (rep_cnt),
    .zero     (rep_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pat_q <= '0;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              pat_q <= pattern;
              len_q <= len_c;
              state <= SHIFT;
            end else begin
              state <= DONE;
            end
          end
        end
        SHIFT: begin
          if (abort) begin
            state <= IDLE;
          end else if (idx_zero) begin
            if (rep_zero) begin
              state <= DONE;
            end else begin
`ifdef SEQGEN_GAP_EN
              state <= GAP;
`else
              state <= SHIFT;
`endif
            end
          end
        end
`ifdef SEQGEN_GAP_EN
        GAP: begin
          state <= abort ? IDLE : SHIFT;
        end
`endif
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Moore decode from registered state and capture registers only.
  assign ready   = (state == IDLE);
  assign O_valid = (state == SHIFT);
  assign O       = O_valid & pat_q[idx];
  assign done    = (state == DONE);

endmodule

// File: tb/tb_fsm_sequence_generator.sv
// Directed and randomised bench for fsm_sequence_generator with a cycle-queue
// reference model of the expected serial stream.
module tb_fsm_sequence_generator;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [7:0] pattern = '0;
  logic [3:0] len = '0;
  logic [3:0] reps = '0;
  logic       abort = 1'b0;
  logic       ready, O, O_valid, done;

  int checks = 0;
  int errors = 0;
  int dut_dones = 0;
  int accepted = 0;

  fsm_sequence_generator dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .pattern (pattern),
    .len     (len),
    .reps    (reps),
    .abort   (abort),
    .ready   (ready),
    .O       (O),
    .O_valid (O_valid),
    .done    (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v;
    logic o;
    logic d;
  } cyc_t;

  cyc_t exp_q[$];

  // Expected output of every cycle of one accepted transfer.
  function automatic void push_transfer(input logic [7:0] p, input int l, input int r);
    int lc;
    cyc_t c;
    lc = (l > 8) ? 8 : l;
    if (lc != 0) begin
      for (int pass = 0; pass <= r; pass++) begin
`ifdef SEQGEN_GAP_EN
        if (pass > 0) begin
          c = '{v: 1'b0, o: 1'b0, d: 1'b0};
          exp_q.push_back(c);
        end
`endif
        for (int b = lc - 1; b >= 0; b--) begin
          c = '{v: 1'b1, o: p[b], d: 1'b0};
          exp_q.push_back(c);
        end
      end
    end
    c = '{v: 1'b0, o: 1'b0, d: 1'b1};
    exp_q.push_back(c);
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
    end else if (exp_q.size() == 0) begin
      if (start) begin
        accepted++;
        push_transfer(pattern, int'(len), int'(reps));
      end
    end else begin
      void'(exp_q.pop_front());
      if (abort) exp_q.delete();
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Advance to the next falling edge and compare all outputs against the model.
  task automatic tick();
    logic [3:0] expv;
    @(negedge clk);
    if (!rst) begin
      if (exp_q.size() == 0) expv = 4'b1000;
      else expv = {1'b0, exp_q[0].v, exp_q[0].o, exp_q[0].d};
      chk("stream {ready,O_valid,O,done}", {28'd0, ready, O_valid, O, done}, {28'd0, expv});
    end
    if (done) dut_dones++;
  endtask

  task automatic transfer(input logic [7:0] p, input logic [3:0] l, input logic [3:0] r,
                          output logic [31:0] bits, output int nbits, output int done_at);
    int k;
    tick();
    pattern = p;
    len = l;
    reps = r;
    start = 1'b1;
    tick();
    start = 1'b0;
    bits = '0;
    nbits = 0;
    done_at = -1;
    k = 1;
    while (k <= 200) begin
      if (O_valid) begin
        bits = {bits[30:0], O};
        nbits++;
      end
      if (done) begin
        done_at = k;
        break;
      end
      tick();
      k++;
    end
    tick();
    chk("ready_after_done", {31'd0, ready}, 32'd1);
  endtask

  logic [31:0] bits;
  int nbits, done_at, w, base_acc, base_done;

  initial begin
    @(negedge clk);
    rst = 1'b1;
    #2;
    chk("reset_ready", {31'd0, ready}, 32'd1);
    chk("reset_O_valid_O_done", {29'd0, O_valid, O, done}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    transfer(8'b0000_0101, 4'd3, 4'd0, bits, nbits, done_at);
    chk("p101_bits", bits, 32'b101);
    chk("p101_nbits", nbits, 3);
    chk("p101_done_at", done_at, 4);

    transfer(8'b0000_0101, 4'd3, 4'd2, bits, nbits, done_at);
    chk("rep2_bits", bits, 32'b101101101);
    chk("rep2_nbits", nbits, 9);
`ifdef SEQGEN_GAP_EN
    chk("rep2_done_at", done_at, 12);
`else
    chk("rep2_done_at", done_at, 10);
`endif

    transfer(8'hFF, 4'd0, 4'd3, bits, nbits, done_at);
    chk("len0_nbits", nbits, 0);
    chk("len0_done_at", done_at, 1);

    transfer(8'hA5, 4'd10, 4'd0, bits, nbits, done_at);
    chk("clamp_bits", bits, 32'hA5);
    chk("clamp_nbits", nbits, 8);
    chk("clamp_done_at", done_at, 9);

    // Abort on the second bit; a start mid-run must be ignored.
    tick();
    pattern = 8'b0000_0101;
    len = 4'd3;
    reps = 4'd1;
    start = 1'b1;
    tick();
    chk("abort_bit1", {30'd0, O_valid, O}, 32'b11);
    pattern = 8'h00;
    len = 4'd8;
    tick();
    chk("abort_bit2", {30'd0, O_valid, O}, 32'b10);
    start = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_idle", {29'd0, ready, O_valid, done}, 32'b100);
    tick();
    chk("abort_no_done", {31'd0, done}, 32'd0);

    // Asynchronous reset between edges in the middle of a transfer.
    tick();
    pattern = 8'hFF;
    len = 4'd8;
    reps = 4'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("pre_rst_valid", {31'd0, O_valid}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("arst_ready", {31'd0, ready}, 32'd1);
    chk("arst_O_valid_O_done", {29'd0, O_valid, O, done}, 32'd0);
    tick();
    rst = 1'b0;
    transfer(8'b0000_0110, 4'd3, 4'd0, bits, nbits, done_at);
    chk("post_rst_bits", bits, 32'b110);
    chk("post_rst_done_at", done_at, 4);

    base_acc = accepted;
    base_done = dut_dones;
    for (int n = 0; n < 500; n++) begin
      w = 0;
      while (exp_q.size() != 0 && w < 300) begin
        tick();
        w++;
      end
      if (exp_q.size() != 0) chk("idle_timeout", 32'(exp_q.size()), 32'd0);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      pattern = 8'($urandom);
      len = 4'($urandom_range(0, 15));
      reps = 4'($urandom_range(0, 3));
      start = 1'b1;
      tick();
      start = 1'b0;
      w = 0;
      while (exp_q.size() != 0 && w < 300) begin
        pattern = 8'($urandom);
        len = 4'($urandom);
        reps = 4'($urandom);
        start = ($urandom_range(0, 3) == 0);
        tick();
        w++;
      end
      start = 1'b0;
    end
    tick();
    chk("random_accepted", 32'(accepted - base_acc), 32'd500);
    chk("random_done_count", 32'(dut_dones - base_done), 32'(accepted - base_acc));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
